// File: rtl/ca3_hash_pkg.sv
// Shared definitions for the hash sequencer: FSM encoding, default sizes and
// the rotate helpers used by the round function.
package ca3_hash_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    MIX    = 2'd2,
    DONE   = 2'd3
  } ca3_state_e;

  localparam int CA3_W_DEF      = 8;
  localparam int CA3_ROUNDS_DEF = 2;
  // The rotate helpers work on a fixed carrier width; callers cast in and out.
  localparam int CA3_WMAX       = 64;

  function automatic logic [CA3_WMAX-1:0] ca3_mask(input int w);
    logic [CA3_WMAX-1:0] msk;
    msk = '0;
    for (int i = 0; i < CA3_WMAX; i++)
      if (i < w) msk[i] = 1'b1;
    return msk;
  endfunction

  // Valid for 0 < n < w <= CA3_WMAX.
  function automatic logic [CA3_WMAX-1:0] rotl(input logic [CA3_WMAX-1:0] x,
                                               input int w, input int n);
    return ((x << n) | (x >> (w - n))) & ca3_mask(w);
  endfunction

  function automatic logic [CA3_WMAX-1:0] rotr(input logic [CA3_WMAX-1:0] x,
                                               input int w, input int n);
    return ((x >> n) | (x << (w - n))) & ca3_mask(w);
  endfunction

endpackage

// File: rtl/CA3_and_2.sv
// Two-input AND cell used by the round function's nonlinear term.
module CA3_and_2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// File: rtl/ca3_hash_round.sv
// Combinational round function R(H,k) = rotl(H,1) ^ (H & rotr(H,2)) ^ k.
module ca3_hash_round
  import ca3_hash_pkg::*;
#(
  parameter int W = CA3_W_DEF
) (
  input  logic [W-1:0] h,
  input  logic [W-1:0] k,
  output logic [W-1:0] r
);

  logic [W-1:0] h_rl, h_rr2, h_and;

  assign h_rl  = W'(rotl(CA3_WMAX'(h), W, 1));
  assign h_rr2 = W'(rotr(CA3_WMAX'(h), W, 2));

  // One AND cell per bit keeps the nonlinear term mapped onto the library gate.
  for (genvar i = 0; i < W; i++) begin : g_and
    CA3_and_2 u_and (
      .a (h[i]),
      .b (h_rr2[i]),
      .y (h_and[i])
    );
  end

  assign r = h_rl ^ h_and ^ k;

endmodule

// File: rtl/ca3_hash_round_sequencer.sv
// Hash front end: absorbs words over valid/ready, runs ROUNDS mixing rounds per
// word one per clock, then holds the digest until the consumer takes it.
module ca3_hash_round_sequencer
  import ca3_hash_pkg::*;
#(
  parameter int W      = CA3_W_DEF,
  parameter int ROUNDS = CA3_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] seed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] digest,
  output logic         busy
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] RLAST = RW'(ROUNDS - 1);

  ca3_state_e    state, state_nx;
  logic [W-1:0]  h, m, k, h_nx;
  logic [RW-1:0] round;
  logic          last_q;

  // Round 0 mixes in the message word; later rounds use the round index as key.
  assign k = (round == '0) ? m : W'(round);

  ca3_hash_round #(.W(W)) u_round (
    .h (h),
    .k (k),
    .r (h_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ABSORB;
      end
      ABSORB: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = MIX;
      end
      MIX: begin
        if (round == RLAST) state_nx = last_q ? DONE : ABSORB;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h      <= '0;
      m      <= '0;
      round  <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) h <= seed;
        ABSORB: begin
          if (in_valid) begin
            m      <= in_data;
            last_q <= in_last;
            round  <= '0;
          end
        end
        MIX: begin
          h     <= h_nx;
          round <= (round == RLAST) ? '0 : round + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign digest = h;

endmodule

// File: tb/tb_ca3_hash_round_sequencer.sv
// Directed bench: one ROUNDS=1 and one ROUNDS=2 instance share stimulus; each
// step checks only the instance it targets.
module tb_ca3_hash_round_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_last, out_ready;
  logic [7:0] seed, in_data;
  logic       in_ready_1, out_valid_1, busy_1;
  logic       in_ready_2, out_valid_2, busy_2;
  logic [7:0] digest_1, digest_2;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ca3_hash_round_sequencer #(.W(8), .ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .in_valid(in_valid),
    .in_ready(in_ready_1), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_1), .out_ready(out_ready), .digest(digest_1), .busy(busy_1));

  ca3_hash_round_sequencer #(.W(8), .ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .in_valid(in_valid),
    .in_ready(in_ready_2), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_2), .out_ready(out_ready), .digest(digest_2), .busy(busy_2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    seed = '0; in_data = '0;
    step(); step();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rf(input logic [7:0] h, input logic [7:0] k);
    return {h[6:0], h[7]} ^ (h & {h[1:0], h[7:2]}) ^ k;
  endfunction

  initial begin
    logic [7:0] words [4];
    logic [7:0] exp_h;
    int idx, cyc, mixleft;
    logic acc;

    // Reset state of both instances
    do_reset();
    chk("rst_busy_1", {7'd0, busy_1}, 8'd0);
    chk("rst_ovalid_1", {7'd0, out_valid_1}, 8'd0);
    chk("rst_iready_2", {7'd0, in_ready_2}, 8'd0);
    chk("rst_digest_2", digest_2, 8'h00);

    // 1: reset during MIX (ROUNDS=2)
    start = 1'b1; seed = 8'h5A; step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1; step();
    in_valid = 1'b0;
    chk("t1_mix_iready", {7'd0, in_ready_2}, 8'd0);
    chk("t1_mix_busy", {7'd0, busy_2}, 8'd1);
    rst = 1'b1; step();
    chk("t1_rst_busy", {7'd0, busy_2}, 8'd0);
    step(); rst = 1'b0;
    chk("t1_busy", {7'd0, busy_2}, 8'd0);
    chk("t1_ovalid", {7'd0, out_valid_2}, 8'd0);
    chk("t1_iready", {7'd0, in_ready_2}, 8'd0);
    chk("t1_digest", digest_2, 8'h00);

    // 2: ROUNDS=1, seed 00, word 01 -> 01
    do_reset();
    start = 1'b1; seed = 8'h00; in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
    step(); start = 1'b0;
    chk("t2_absorb_iready", {7'd0, in_ready_1}, 8'd1);
    chk("t2_absorb_ovalid", {7'd0, out_valid_1}, 8'd0);
    step(); in_valid = 1'b0;
    chk("t2_mix_iready", {7'd0, in_ready_1}, 8'd0);
    chk("t2_mix_ovalid", {7'd0, out_valid_1}, 8'd0);
    step();
    chk("t2_ovalid", {7'd0, out_valid_1}, 8'd1);
    chk("t2_digest", digest_1, 8'h01);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("t2_idle_busy", {7'd0, busy_1}, 8'd0);

    // 3: ROUNDS=1, seed 80, word 00 -> 01
    do_reset();
    start = 1'b1; seed = 8'h80; step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1; step();
    in_valid = 1'b0; step();
    chk("t3_ovalid", {7'd0, out_valid_1}, 8'd1);
    chk("t3_digest", digest_1, 8'h01);

    // 4: ROUNDS=2, seed 00, word 01 -> 01 then 03
    do_reset();
    start = 1'b1; seed = 8'h00; step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1; step();
    in_valid = 1'b0; step();
    chk("t4_round0_h", digest_2, 8'h01);
    chk("t4_round0_ovalid", {7'd0, out_valid_2}, 8'd0);
    step();
    chk("t4_round1_h", digest_2, 8'h03);
    chk("t4_ovalid", {7'd0, out_valid_2}, 8'd1);

    // 5: multi-word message with in_valid toggling (ROUNDS=2)
    do_reset();
    words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56; words[3] = 8'h78;
    exp_h = 8'hC3;
    for (int i = 0; i < 4; i++) exp_h = rf(rf(exp_h, words[i]), 8'h01);
    start = 1'b1; seed = 8'hC3; step(); start = 1'b0;
    idx = 0; cyc = 0; mixleft = 0;
    while (!out_valid_2 && cyc < 100) begin
      in_valid = (idx < 4) && (cyc % 3 != 1);
      in_data  = (idx < 4) ? words[idx] : 8'h00;
      in_last  = (idx == 3);
      acc = in_valid && in_ready_2;
      if (mixleft > 0) begin
        chk("t5_mix_iready", {7'd0, in_ready_2}, 8'd0);
        mixleft--;
      end
      step();
      if (acc) begin idx++; mixleft = 2; end
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t5_ovalid", {7'd0, out_valid_2}, 8'd1);
    chk("t5_words", 8'(idx), 8'd4);
    chk("t5_digest", digest_2, exp_h);

    // 6: hold DONE with out_ready low and start high, then release with start
    start = 1'b1; seed = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_hold_ovalid", {7'd0, out_valid_2}, 8'd1);
      chk("t6_hold_digest", digest_2, exp_h);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("t6_idle_busy", {7'd0, busy_2}, 8'd0);
    chk("t6_idle_ovalid", {7'd0, out_valid_2}, 8'd0);
    step(); start = 1'b0;
    chk("t6_restart_busy", {7'd0, busy_2}, 8'd1);
    chk("t6_restart_iready", {7'd0, in_ready_2}, 8'd1);
    chk("t6_restart_seed", digest_2, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
